// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard:
// forwarding select encodings, Tuse sentinel and the per-stage entry.
package hazard_scoreboard_pkg;

    localparam int SB_RW = 5;
    localparam int SB_TW = 2;

    // Select codes follow the operand selector input order I0..I3.
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam logic [SB_TW-1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic [SB_RW-1:0] dst;
        logic [SB_TW-1:0] tnew;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '{dst: 5'd0, tnew: 2'd0};

    function automatic logic [SB_TW-1:0] sat_dec(input logic [SB_TW-1:0] x);
        if (x == {SB_TW{1'b0}}) begin
            return {SB_TW{1'b0}};
        end else begin
            return x - {{(SB_TW-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_pick.sv
// Finds the newest stage writing a given register and turns it into a
// forwarding select plus the producer's remaining latency.
module hazard_scoreboard_fwd_pick
    import hazard_scoreboard_pkg::*;
(
    input  logic [SB_RW-1:0] reg_i,
    input  stage_t           e_i,
    input  stage_t           m_i,
    input  stage_t           w_i,
    input  logic             use_e_i,
    output logic             hit_o,
    output logic [SB_TW-1:0] hit_tnew_o,
    output logic [1:0]       sel_o
);

    logic reg_nz_s;
    logic e_hit_s;
    logic m_hit_s;
    logic w_hit_s;

    assign reg_nz_s = (reg_i != {SB_RW{1'b0}});
    assign e_hit_s  = use_e_i && reg_nz_s && (e_i.dst == reg_i);
    assign m_hit_s  = reg_nz_s && (m_i.dst == reg_i);
    assign w_hit_s  = reg_nz_s && (w_i.dst == reg_i);

    // Newest match wins; a newest producer still computing shadows older ones.
    always_comb begin
        hit_o      = 1'b0;
        hit_tnew_o = {SB_TW{1'b0}};
        sel_o      = FWD_RF;
        if (e_hit_s) begin
            hit_o      = 1'b1;
            hit_tnew_o = e_i.tnew;
            sel_o      = (e_i.tnew == {SB_TW{1'b0}}) ? FWD_E : FWD_RF;
        end else if (m_hit_s) begin
            hit_o      = 1'b1;
            hit_tnew_o = m_i.tnew;
            sel_o      = (m_i.tnew == {SB_TW{1'b0}}) ? FWD_M : FWD_RF;
        end else if (w_hit_s) begin
            hit_o      = 1'b1;
            hit_tnew_o = w_i.tnew;
            sel_o      = FWD_W;
        end else begin
            sel_o      = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage core: tracks E/M/W producers and
// derives stall plus D- and E-stage forwarding selects from that state.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int RW = SB_RW,
    parameter int TW = SB_TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] d_rs,
    input  logic [RW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [RW-1:0] d_dst,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_is_md,
    input  logic          mdu_busy,
    input  logic          mdu_start_e,
    output logic          stall,
    output logic [1:0]    fwd_rs_d,
    output logic [1:0]    fwd_rt_d,
    output logic [1:0]    fwd_rs_e,
    output logic [1:0]    fwd_rt_e
);

    stage_t        e_q, e_d;
    stage_t        m_q, m_d;
    stage_t        w_q, w_d;
    logic [RW-1:0] rs_e_q, rs_e_d;
    logic [RW-1:0] rt_e_q, rt_e_d;

    logic          d_hit_rs_s, d_hit_rt_s;
    logic [TW-1:0] d_tnew_rs_s, d_tnew_rt_s;
    logic          unused_e_hit_rs, unused_e_hit_rt;
    logic [TW-1:0] unused_e_tnew_rs, unused_e_tnew_rt;
    logic          rs_hazard_s, rt_hazard_s, mdu_hazard_s;

    hazard_scoreboard_fwd_pick u_pick_rs_d (
        .reg_i(d_rs), .e_i(e_q), .m_i(m_q), .w_i(w_q), .use_e_i(1'b1),
        .hit_o(d_hit_rs_s), .hit_tnew_o(d_tnew_rs_s), .sel_o(fwd_rs_d)
    );

    hazard_scoreboard_fwd_pick u_pick_rt_d (
        .reg_i(d_rt), .e_i(e_q), .m_i(m_q), .w_i(w_q), .use_e_i(1'b1),
        .hit_o(d_hit_rt_s), .hit_tnew_o(d_tnew_rt_s), .sel_o(fwd_rt_d)
    );

    // E-stage operands only look downstream, so the E entry is masked off.
    hazard_scoreboard_fwd_pick u_pick_rs_e (
        .reg_i(rs_e_q), .e_i(e_q), .m_i(m_q), .w_i(w_q), .use_e_i(1'b0),
        .hit_o(unused_e_hit_rs), .hit_tnew_o(unused_e_tnew_rs), .sel_o(fwd_rs_e)
    );

    hazard_scoreboard_fwd_pick u_pick_rt_e (
        .reg_i(rt_e_q), .e_i(e_q), .m_i(m_q), .w_i(w_q), .use_e_i(1'b0),
        .hit_o(unused_e_hit_rt), .hit_tnew_o(unused_e_tnew_rt), .sel_o(fwd_rt_e)
    );

    assign rs_hazard_s  = d_hit_rs_s && (d_tnew_rs_s > d_tuse_rs);
    assign rt_hazard_s  = d_hit_rt_s && (d_tnew_rt_s > d_tuse_rt);
    assign mdu_hazard_s = d_is_md && (mdu_busy || mdu_start_e);
    assign stall        = rs_hazard_s || rt_hazard_s || mdu_hazard_s;

    // Advance the scoreboard; a stall injects a bubble into E while M and W drain.
    always_comb begin
        w_d    = '{dst: m_q.dst, tnew: sat_dec(m_q.tnew)};
        m_d    = '{dst: e_q.dst, tnew: sat_dec(e_q.tnew)};
        e_d    = STAGE_EMPTY;
        rs_e_d = {RW{1'b0}};
        rt_e_d = {RW{1'b0}};
        if (stall) begin
            e_d    = STAGE_EMPTY;
            rs_e_d = {RW{1'b0}};
            rt_e_d = {RW{1'b0}};
        end else begin
            e_d    = '{dst: d_dst, tnew: d_tnew};
            rs_e_d = d_rs;
            rt_e_d = d_rt;
        end
    end

    // Scoreboard state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= STAGE_EMPTY;
            m_q    <= STAGE_EMPTY;
            w_q    <= STAGE_EMPTY;
            rs_e_q <= {RW{1'b0}};
            rt_e_q <= {RW{1'b0}};
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            rs_e_q <= rs_e_d;
            rt_e_q <= rt_e_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use stall, forwarding paths,
// newest-producer shadowing, register 0, MDU stalls and reset mid-stall.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_is_md, mdu_busy, mdu_start_e;
    logic       stall;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew), .d_is_md(d_is_md),
        .mdu_busy(mdu_busy), .mdu_start_e(mdu_start_e),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] trs, input logic [1:0] trt,
                         input logic [4:0] dst, input logic [1:0] tn);
        d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
        d_dst = dst; d_tnew = tn;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0);
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic st, input logic [1:0] rsd,
                           input logic [1:0] rtd, input logic [1:0] rse, input logic [1:0] rte);
        chk({tag, "_stall"}, {1'b0, stall}, {1'b0, st});
        chk({tag, "_rs_d"}, fwd_rs_d, rsd);
        chk({tag, "_rt_d"}, fwd_rt_d, rtd);
        chk({tag, "_rs_e"}, fwd_rs_e, rse);
        chk({tag, "_rt_e"}, fwd_rt_e, rte);
    endtask

    initial begin
        reset = 1'b1; d_is_md = 1'b0; mdu_busy = 1'b0; mdu_start_e = 1'b0;
        idle();
        tick(); tick();
        reset = 1'b0;
        #1;
        chk_all("reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);

        // load-use: producer reg 8 tnew 1, consumer needs it at tuse 0
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1);
        chk({"lu_issue"}, {1'b0, stall}, 2'd0);
        tick();
        drive(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
        chk("lu_stall", {1'b0, stall}, 2'd1);
        chk("lu_rs_d_blocked", fwd_rs_d, 2'd0);
        tick();
        chk("lu_release", {1'b0, stall}, 2'd0);
        chk("lu_rs_d_m", fwd_rs_d, 2'd2);
        tick();
        idle();
        chk("lu_rs_e_w", fwd_rs_e, 2'd3);
        chk("lu_no_stall", {1'b0, stall}, 2'd0);
        tick();

        // ALU producer reg 9, consumers at tuse 1
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1);
        tick();
        drive(5'd0, 5'd9, 2'd3, 2'd1, 5'd0, 2'd0);
        chk("alu_no_stall", {1'b0, stall}, 2'd0);
        chk("alu_rt_d_pending", fwd_rt_d, 2'd0);
        tick();
        drive(5'd0, 5'd9, 2'd3, 2'd1, 5'd0, 2'd0);
        chk("alu_rt_e_m", fwd_rt_e, 2'd2);
        chk("alu_rt_d_m", fwd_rt_d, 2'd2);
        chk("alu_no_stall2", {1'b0, stall}, 2'd0);
        tick();
        idle();
        chk("alu_rt_e_w", fwd_rt_e, 2'd3);
        chk("w_tnew_zero", dut.w_q.tnew, 2'd0);
        tick(); tick(); tick();

        // two writers to reg 5: the newest must win
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1);
        tick();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd0);
        chk("ww_no_stall", {1'b0, stall}, 2'd0);
        tick();
        drive(5'd5, 5'd0, 2'd0, 2'd3, 5'd5, 2'd2);
        chk("ww_rs_d_e", fwd_rs_d, 2'd1);
        chk("ww_no_stall2", {1'b0, stall}, 2'd0);
        tick();
        // newest producer (tnew 2) shadows a ready older one in M
        drive(5'd5, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0);
        chk("shadow_stall", {1'b0, stall}, 2'd1);
        chk("shadow_rs_d", fwd_rs_d, 2'd0);
        chk("shadow_rs_e_m", fwd_rs_e, 2'd2);
        tick();
        chk("shadow_release", {1'b0, stall}, 2'd0);
        chk("shadow_m_pending", fwd_rs_d, 2'd0);
        tick();
        idle();
        chk("shadow_rs_e_w", fwd_rs_e, 2'd3);
        tick();

        // register 0 never matches
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd2);
        tick();
        drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        chk_all("r0", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        idle(); tick(); tick();

        // MDU busy for 4 cycles
        d_is_md = 1'b1; mdu_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mdu_busy_stall", {1'b0, stall}, 2'd1);
            tick();
        end
        mdu_busy = 1'b0;
        #1;
        chk("mdu_release", {1'b0, stall}, 2'd0);
        d_is_md = 1'b0; mdu_busy = 1'b1;
        #1;
        chk("mdu_not_md", {1'b0, stall}, 2'd0);
        mdu_busy = 1'b0; mdu_start_e = 1'b1; d_is_md = 1'b1;
        #1;
        chk("mdu_start", {1'b0, stall}, 2'd1);
        d_is_md = 1'b0;
        #1;
        chk("mdu_start_not_md", {1'b0, stall}, 2'd0);
        mdu_start_e = 1'b0;
        tick();

        // reset asserted during a load-use stall
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1);
        tick();
        drive(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
        chk("rst_pre_stall", {1'b0, stall}, 2'd1);
        reset = 1'b1;
        tick();
        chk_all("rst_mid", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        reset = 1'b0;
        idle();
        tick();
        chk_all("rst_after", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Tracks destination register and remaining result latency (Tnew) of the instructions in E, M and W in an internal scoreboard.
- Produces the stall/bubble signal and the 2-bit forwarding select codes that drive the Op inputs of the core's 4-input operand selectors, for both the D-stage and E-stage operands.
- Sits beside the pipeline registers and is the producer side of every forwarding selector.

Parameters:
- RW, 5, register address width.
- TW, 2, Tnew/Tuse counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- d_rs  input  RW  D-stage source register 1.
- d_rt  input  RW  D-stage source register 2.
- d_tuse_rs  input  TW  cycles until D instruction needs rs (3 = not used).
- d_tuse_rt  input  TW  cycles until D instruction needs rt (3 = not used).
- d_dst  input  RW  D-stage destination (0 = no write).
- d_tnew  input  TW  cycles from E entry until result is forwardable.
- d_is_md  input  1  D instruction uses MDU/HI/LO.
- mdu_busy  input  1  MDU is iterating.
- mdu_start_e  input  1  E-stage instruction starts the MDU this cycle.
- stall  output  1  freeze PC and F/D; insert bubble into E.
- fwd_rs_d  output  2  D-stage rs select.
- fwd_rt_d  output  2  D-stage rt select.
- fwd_rs_e  output  2  E-stage rs select.
- fwd_rt_e  output  2  E-stage rt select.

Behaviour:
- Scoreboard entries E, M, W each hold dst[RW-1:0] and tnew[TW-1:0]. The E entry also holds rs_e and rt_e.
- Reset (synchronous, active-high):
  - All entries set dst=0, tnew=0, rs_e=0, rt_e=0.
  - Outputs derive from state, so after reset stall=0 and all fwd_*=2'd0.
  - Reset asserted mid-stall clears the stall on the following edge.
- Every clock edge (no reset):
  - W <= {M.dst, sat_dec(M.tnew)}.
  - M <= {E.dst, sat_dec(E.tnew)}.
  - If stall: E <= bubble (dst=0, tnew=0, rs_e=0, rt_e=0).
  - Else: E <= {d_dst, d_tnew, d_rs, d_rt}.
  - sat_dec(x) = x==0 ? 0 : x-1.
- W.tnew is always 0 by construction; the bench checks this invariant.
- Matching:
  - A stage matches register r iff r != 0 and stage.dst == r.
  - Register 0 never matches, never stalls and never forwards.
- Stall (combinational):
  - Data hazard on rs: the newest matching stage among E then M has tnew > d_tuse_rs. The same rule applies to rt.
  - Only the newest match is considered. An older producer is shadowed by a newer one.
  - MDU hazard: d_is_md && (mdu_busy || mdu_start_e).
  - stall = rs_hazard | rt_hazard | mdu_hazard.
- D forward select:
  - 2'd1 if E matches and E.tnew==0.
  - Else 2'd2 if M matches and M.tnew==0.
  - Else 2'd3 if W matches.
  - Else 2'd0 (register file).
  - A newer match with tnew>0 forces 2'd0. This is legal only because stall is asserted in that case.
- E forward select:
  - Uses rs_e/rt_e against M then W: 2'd2 if M matches and M.tnew==0, 2'd3 if W matches, else 2'd0.
  - 2'd1 is never produced for E selects.
- Select encoding is fixed: 0=RF, 1=E result, 2=M result, 3=W result. It matches the selector input order I0..I3.
- Simultaneous hazards: any one asserts stall. Forward selects stay valid during stall and are ignored by the datapath.
- Repeated stalls: E keeps receiving bubbles while M and W drain. The stall releases in the first cycle the condition is false, with no extra cycle.

Decomposition:
- Shared package holds:
  - FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3.
  - TUSE_NONE=3.
  - The stage entry typedef {dst, tnew}.
- One natural sub-module, fwd_pick: given a register and the newest-first stage entries, returns the match flag and select code. It is instantiated 4 times.

Test Plan:
- Reset → stall=0, all fwd=0. Issue d_dst=8, d_tnew=1, then D with d_rs=8, d_tuse_rs=0 → stall=1 for exactly 1 cycle. Next cycle fwd_rs_d=2.
- ALU producer d_dst=9, d_tnew=1, next D d_rt=9, d_tuse_rt=1 → stall=0, fwd_rt_e=2 one cycle later. Cycle after, an E consumer of reg 9 sees fwd_rt_e=3.
- Two back-to-back writers to reg 5 (tnew 1 then 0), consumer d_rs=5, d_tuse_rs=0 → fwd_rs_d=1 (newest wins), not 2.
- d_rs=0 with E.dst=0 bubble or any producer → stall=0, fwd_rs_d=0.
- d_is_md=1 while mdu_busy=1 for 4 cycles → stall=1 for exactly 4 cycles. mdu_start_e=1 alone → stall=1 that cycle.
- Assert reset during a load-use stall → next cycle stall=0, scoreboard empty, all fwd=0.
